issue_unit: RTL

//  Issue stage of the Tomasulo core. Takes one instruction per cycle from the instruction queue.

---
 rtl/issue_unit_pkg.sv | 75 +++++++
 rtl/issue_unit_decoder.sv | 125 ++++++++++++
 rtl/issue_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/issue_unit_pkg.sv
// Shared definitions for the issue stage: internal opcode codes, tag widths,
// instruction formats and the resolved-operand record.
package issue_unit_pkg;

  localparam int ROB_W = 4;
  localparam int OPC_W = 6;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // Internal opcodes, shared with the RS/ALU and LSB.
  localparam logic [OPC_W-1:0] OPC_ILL   = 6'd0;
  localparam logic [OPC_W-1:0] OPC_LUI   = 6'd1;
  localparam logic [OPC_W-1:0] OPC_AUIPC = 6'd2;
  localparam logic [OPC_W-1:0] OPC_JAL   = 6'd3;
  localparam logic [OPC_W-1:0] OPC_JALR  = 6'd4;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'd5;
  localparam logic [OPC_W-1:0] OPC_BNE   = 6'd6;
  localparam logic [OPC_W-1:0] OPC_BLT   = 6'd7;
  localparam logic [OPC_W-1:0] OPC_BGE   = 6'd8;
  localparam logic [OPC_W-1:0] OPC_BLTU  = 6'd9;
  localparam logic [OPC_W-1:0] OPC_BGEU  = 6'd10;
  localparam logic [OPC_W-1:0] OPC_LB    = 6'd11;
  localparam logic [OPC_W-1:0] OPC_LH    = 6'd12;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'd13;
  localparam logic [OPC_W-1:0] OPC_LBU   = 6'd14;
  localparam logic [OPC_W-1:0] OPC_LHU   = 6'd15;
  localparam logic [OPC_W-1:0] OPC_SB    = 6'd16;
  localparam logic [OPC_W-1:0] OPC_SH    = 6'd17;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'd18;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'd19;
  localparam logic [OPC_W-1:0] OPC_SLTI  = 6'd20;
  localparam logic [OPC_W-1:0] OPC_SLTIU = 6'd21;
  localparam logic [OPC_W-1:0] OPC_XORI  = 6'd22;
  localparam logic [OPC_W-1:0] OPC_ORI   = 6'd23;
  localparam logic [OPC_W-1:0] OPC_ANDI  = 6'd24;
  localparam logic [OPC_W-1:0] OPC_SLLI  = 6'd25;
  localparam logic [OPC_W-1:0] OPC_SRLI  = 6'd26;
  localparam logic [OPC_W-1:0] OPC_SRAI  = 6'd27;
  localparam logic [OPC_W-1:0] OPC_ADD   = 6'd28;
  localparam logic [OPC_W-1:0] OPC_SUB   = 6'd29;
  localparam logic [OPC_W-1:0] OPC_SLL   = 6'd30;
  localparam logic [OPC_W-1:0] OPC_SLT   = 6'd31;
  localparam logic [OPC_W-1:0] OPC_SLTU  = 6'd32;
  localparam logic [OPC_W-1:0] OPC_XOR   = 6'd33;
  localparam logic [OPC_W-1:0] OPC_SRL   = 6'd34;
  localparam logic [OPC_W-1:0] OPC_SRA   = 6'd35;
  localparam logic [OPC_W-1:0] OPC_OR    = 6'd36;
  localparam logic [OPC_W-1:0] OPC_AND   = 6'd37;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH
  } fmt_t;

  typedef struct packed {
    logic [31:0] val;
    logic        rdy;
  } opnd_t;

  // Sign-extended immediate for each RV32I format; shift amounts zero-extend.
  function automatic logic [31:0] imm_gen(input fmt_t fmt, input logic [31:0] inst);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'd0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_SH:  imm = {27'd0, inst[24:20]};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/issue_unit_decoder.sv
// Combinational RV32I decoder: raw instruction to internal opcode, rd,
// source-use flags, immediate, memory routing and illegal flag.
module issue_unit_decoder
  import issue_unit_pkg::*;
(
  input  logic [31:0]      inst,
  output logic [OPC_W-1:0] opcode,
  output logic [4:0]       rd,
  output logic             rs1_used,
  output logic             rs2_used,
  output logic [31:0]      imm,
  output logic             is_mem,
  output logic             illegal
);

  logic [2:0] f3;
  logic [6:0] f7;
  fmt_t       fmt;
  logic       has_rd;
  logic       mem_raw;

  assign f3 = inst[14:12];
  assign f7 = inst[31:25];

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    opcode   = OPC_ILL;
    fmt      = FMT_R;
    has_rd   = False;
    rs1_used = False;
    rs2_used = False;
    mem_raw  = False;
    case (inst[6:0])
      7'b0110111: begin opcode = OPC_LUI;   fmt = FMT_U; has_rd = True; end
      7'b0010111: begin opcode = OPC_AUIPC; fmt = FMT_U; has_rd = True; end
      7'b1101111: begin opcode = OPC_JAL;   fmt = FMT_J; has_rd = True; end
      7'b1100111: begin
        fmt = FMT_I; has_rd = True; rs1_used = True;
        if (f3 == 3'b000) opcode = OPC_JALR;
      end
      7'b1100011: begin
        fmt = FMT_B; rs1_used = True; rs2_used = True;
        case (f3)
          3'b000:  opcode = OPC_BEQ;
          3'b001:  opcode = OPC_BNE;
          3'b100:  opcode = OPC_BLT;
          3'b101:  opcode = OPC_BGE;
          3'b110:  opcode = OPC_BLTU;
          3'b111:  opcode = OPC_BGEU;
          default: ;
        endcase
      end
      7'b0000011: begin
        fmt = FMT_I; has_rd = True; rs1_used = True; mem_raw = True;
        case (f3)
          3'b000:  opcode = OPC_LB;
          3'b001:  opcode = OPC_LH;
          3'b010:  opcode = OPC_LW;
          3'b100:  opcode = OPC_LBU;
          3'b101:  opcode = OPC_LHU;
          default: ;
        endcase
      end
      7'b0100011: begin
        fmt = FMT_S; rs1_used = True; rs2_used = True; mem_raw = True;
        case (f3)
          3'b000:  opcode = OPC_SB;
          3'b001:  opcode = OPC_SH;
          3'b010:  opcode = OPC_SW;
          default: ;
        endcase
      end
      7'b0010011: begin
        fmt = FMT_I; has_rd = True; rs1_used = True;
        case (f3)
          3'b000: opcode = OPC_ADDI;
          3'b010: opcode = OPC_SLTI;
          3'b011: opcode = OPC_SLTIU;
          3'b100: opcode = OPC_XORI;
          3'b110: opcode = OPC_ORI;
          3'b111: opcode = OPC_ANDI;
          3'b001: begin
            fmt = FMT_SH;
            if (f7 == 7'b0000000) opcode = OPC_SLLI;
          end
          default: begin
            fmt = FMT_SH;
            if (f7 == 7'b0000000)      opcode = OPC_SRLI;
            else if (f7 == 7'b0100000) opcode = OPC_SRAI;
          end
        endcase
      end
      7'b0110011: begin
        fmt = FMT_R; has_rd = True; rs1_used = True; rs2_used = True;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  opcode = OPC_ADD;
            3'b001:  opcode = OPC_SLL;
            3'b010:  opcode = OPC_SLT;
            3'b011:  opcode = OPC_SLTU;
            3'b100:  opcode = OPC_XOR;
            3'b101:  opcode = OPC_SRL;
            3'b110:  opcode = OPC_OR;
            default: opcode = OPC_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  opcode = OPC_SUB;
            3'b101:  opcode = OPC_SRA;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // An illegal encoding never renames a register nor reaches the LSB.
  assign illegal = (opcode == OPC_ILL);
  assign rd      = (has_rd && !illegal) ? inst[11:7] : 5'd0;
  assign is_mem  = mem_raw && !illegal;
  assign imm     = imm_gen(fmt, inst);

endmodule

// File: rtl/issue_unit.sv
// Tomasulo issue stage: pops one instruction per cycle, resolves both operands
// and dispatches to ROB plus either the ALU reservation station or the LSB.
module issue_unit
  import issue_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             IQ_sgn,
  input  logic [31:0]      IQ_inst,
  input  logic [31:0]      IQ_pc,
  output logic             IQ_pop,
  output logic [4:0]       RF_rs1,
  output logic [4:0]       RF_rs2,
  input  logic             RF_busy1,
  input  logic [31:0]      RF_val1,
  input  logic [ROB_W-1:0] RF_tag1,
  input  logic             RF_busy2,
  input  logic [31:0]      RF_val2,
  input  logic [ROB_W-1:0] RF_tag2,
  input  logic             ROB_rdy1,
  input  logic [31:0]      ROB_val1,
  input  logic             ROB_rdy2,
  input  logic [31:0]      ROB_val2,
  input  logic [ROB_W-1:0] ROB_name,
  input  logic             ROB_full,
  input  logic             RS_full,
  input  logic             LSB_full,
  input  logic             ROB_clr,
  input  logic             CDBA_sgn,
  input  logic [31:0]      CDBA_result,
  input  logic [ROB_W-1:0] CDBA_ROB_name,
  input  logic             CDBD_sgn,
  input  logic [31:0]      CDBD_result,
  input  logic [ROB_W-1:0] CDBD_ROB_name,
  output logic             ROB_sgn,
  output logic [OPC_W-1:0] ROB_opcode,
  output logic [4:0]       ROB_rd,
  output logic [31:0]      ROB_pc,
  output logic [31:0]      ROB_imm,
  output logic             RF_sgn,
  output logic [4:0]       RF_rd,
  output logic [ROB_W-1:0] RF_tag,
  output logic             RS_sgn,
  output logic [OPC_W-1:0] RS_opcode,
  output logic [31:0]      RS_rs1_val,
  output logic [31:0]      RS_rs2_val,
  output logic             RS_rs1_rdy,
  output logic             RS_rs2_rdy,
  output logic             LSB_sgn,
  output logic [OPC_W-1:0] LSB_opcode,
  output logic [31:0]      LSB_rs1_val,
  output logic [31:0]      LSB_rs2_val,
  output logic             LSB_rs1_rdy,
  output logic             LSB_rs2_rdy,
  output logic [31:0]      LSB_imm
);

  logic [OPC_W-1:0] d_opcode;
  logic [4:0]       d_rd;
  logic             d_rs1_used;
  logic             d_rs2_used;
  logic [31:0]      d_imm;
  logic             d_is_mem;
  logic             d_illegal;

  logic             last_vld;
  logic [4:0]       last_rd;
  logic [ROB_W-1:0] last_tag;

  logic             fire;
  opnd_t            op1, op2, src1, src2;

  issue_unit_decoder u_dec (
    .inst     (IQ_inst),
    .opcode   (d_opcode),
    .rd       (d_rd),
    .rs1_used (d_rs1_used),
    .rs2_used (d_rs2_used),
    .imm      (d_imm),
    .is_mem   (d_is_mem),
    .illegal  (d_illegal)
  );

  assign RF_rs1 = IQ_inst[19:15];
  assign RF_rs2 = IQ_inst[24:20];

  assign fire   = rdy && IQ_sgn && !ROB_full && !(d_is_mem ? LSB_full : RS_full) && !ROB_clr;
  assign IQ_pop = fire;

  // The previous issue's rename is not yet visible in the RF, so it is checked
  // ahead of the RF busy bit.
  function automatic opnd_t resolve(input logic [4:0]       idx,
                                    input logic             busy,
                                    input logic [31:0]      rf_val,
                                    input logic [ROB_W-1:0] tag,
                                    input logic             rob_rdy,
                                    input logic [31:0]      rob_val);
    opnd_t r;
    if (idx == 5'd0)                           r = '{val: 32'd0, rdy: True};
    else if (last_vld && last_rd == idx)       r = '{val: {{(32-ROB_W){1'b0}}, last_tag}, rdy: False};
    else if (!busy)                            r = '{val: rf_val, rdy: True};
    else if (rob_rdy)                          r = '{val: rob_val, rdy: True};
    else if (CDBA_sgn && CDBA_ROB_name == tag) r = '{val: CDBA_result, rdy: True};
    else if (CDBD_sgn && CDBD_ROB_name == tag) r = '{val: CDBD_result, rdy: True};
    else                                       r = '{val: {{(32-ROB_W){1'b0}}, tag}, rdy: False};
    return r;
  endfunction

  always_comb begin
    op1  = resolve(d_rs1_used ? RF_rs1 : 5'd0, RF_busy1, RF_val1, RF_tag1, ROB_rdy1, ROB_val1);
    op2  = resolve(d_rs2_used ? RF_rs2 : 5'd0, RF_busy2, RF_val2, RF_tag2, ROB_rdy2, ROB_val2);
    src1 = op1;
    src2 = op2;
    if (d_opcode == OPC_AUIPC || d_opcode == OPC_JAL)
      src1 = '{val: IQ_pc, rdy: True};
    if (!d_rs2_used)
      src2 = '{val: (d_opcode == OPC_JALR) ? IQ_pc : d_imm, rdy: True};
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ROB_sgn     <= 1'b0;
      ROB_opcode  <= '0;
      ROB_rd      <= '0;
      ROB_pc      <= '0;
      ROB_imm     <= '0;
      RF_sgn      <= 1'b0;
      RF_rd       <= '0;
      RF_tag      <= '0;
      RS_sgn      <= 1'b0;
      RS_opcode   <= '0;
      RS_rs1_val  <= '0;
      RS_rs2_val  <= '0;
      RS_rs1_rdy  <= 1'b0;
      RS_rs2_rdy  <= 1'b0;
      LSB_sgn     <= 1'b0;
      LSB_opcode  <= '0;
      LSB_rs1_val <= '0;
      LSB_rs2_val <= '0;
      LSB_rs1_rdy <= 1'b0;
      LSB_rs2_rdy <= 1'b0;
      LSB_imm     <= '0;
      last_vld    <= 1'b0;
      last_rd     <= '0;
      last_tag    <= '0;
    end else if (rdy) begin
      ROB_sgn  <= fire;
      RF_sgn   <= fire && d_rd != 5'd0;
      RS_sgn   <= fire && !d_is_mem && !d_illegal;
      LSB_sgn  <= fire && d_is_mem;
      // One cycle after an issue its rename is visible in the RF, so the
      // bypass is only kept across back-to-back issues.
      last_vld <= fire && d_rd != 5'd0;
      if (fire) begin
        ROB_opcode  <= d_opcode;
        ROB_rd      <= d_rd;
        ROB_pc      <= IQ_pc;
        ROB_imm     <= d_imm;
        RF_rd       <= d_rd;
        RF_tag      <= ROB_name;
        RS_opcode   <= d_opcode;
        RS_rs1_val  <= src1.val;
        RS_rs2_val  <= src2.val;
        RS_rs1_rdy  <= src1.rdy;
        RS_rs2_rdy  <= src2.rdy;
        LSB_opcode  <= d_opcode;
        LSB_rs1_val <= src1.val;
        LSB_rs2_val <= src2.val;
        LSB_rs1_rdy <= src1.rdy;
        LSB_rs2_rdy <= src2.rdy;
        LSB_imm     <= d_imm;
        if (d_rd != 5'd0) begin
          last_rd  <= d_rd;
          last_tag <= ROB_name;
        end
      end
    end
  end

endmodule
